sig_data_tmu_sched: RTL and testbench
=====================================

# sig_data_tmu_sched

Frame-level scheduler for the transmit tone-mapping stage. It sits between the channel encoder's serial bit stream and the two tone mappers: the signal tone map unit (QPSK, one OFDM symbol) and the data tone map unit (BPSK/QPSK/16QAM). For each frame it routes exactly one signal symbol's bits, then `n_sym` data symbols' bits, to the correct mapper. Bits are delivered in gap-free groups of one tone each, because both mappers restart their bit grouping whenever `di_vld` drops. It also marks symbol boundaries for the downstream scrambler/IFFT loader.

## Interface
- `N_TONE`, 480: used sub-carriers per OFDM symbol (N = 512, centre 480)
- `SYM_W`, 8: width of data-symbol count
- `clk`  in  1  working clock
- `rst`  in  1  asynchronous reset, active low
- `start`  in  1  one-cycle frame start pulse; honoured only in IDLE
- `mod_sel`  in  2  data modulation: 0 BPSK (1 bit/tone), 1 QPSK (2), 2 16QAM (4), 3 reserved (treated as QPSK); latched on accepted `start`
- `n_sym`  in  SYM_W  number of data symbols; latched on accepted `start`; 0 = signal only
- `enc_di`  in  1  encoded bit from channel encoder
- `enc_vld`  in  1  `enc_di` valid
- `enc_rdy`  out  1  bit accepted on a cycle where `enc_vld && enc_rdy`
- `stmu_di` / `stmu_di_vld`  out  1 / 1  bit stream to signal tone mapper
- `dtmu_di` / `dtmu_di_vld`  out  1 / 1  bit stream to data tone mapper
- `sym_first`  out  1  high with the first emitted bit of tone 0 of every symbol (signal and data)
- `tone_idx`  out  9  index (0..N_TONE-1) of the tone currently being emitted
- `sym_idx`  out  SYM_W  0 during signal symbol; 1..n_sym during data symbols
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at frame end

## Operation
- Bits per tone: k = 2 in signal phase. In data phase, k = 1/2/4 per the latched `mod_sel`.
- States: IDLE, SIG_COL, SIG_EMIT, DAT_COL, DAT_EMIT, FIN.
- IDLE:
  - `busy` = 0 and `enc_rdy` = 0.
  - On `start`: latch `mod_sel` and `n_sym`, clear counters, go to SIG_COL.
- *_COL states:
  - `enc_rdy` = 1.
  - Accepted bits shift into a 4-bit staging register in arrival order.
  - When the k-th bit is accepted, go to the matching *_EMIT state.
- *_EMIT states:
  - `enc_rdy` = 0.
  - Drive the k staged bits on the selected mapper port, first-received bit first, one per cycle.
  - `*_di_vld` is held high for exactly k consecutive cycles.
  - The unselected port's `di` and `di_vld` are 0.
- End of each emit:
  - If `tone_idx` < N_TONE-1: increment `tone_idx` and return to the same phase's COL.
  - Otherwise wrap `tone_idx` to 0, then:
    - In SIG: go to DAT_COL with `sym_idx` = 1 if `n_sym` ≠ 0, else go to FIN.
    - In DAT: if `sym_idx` == `n_sym`, go to FIN; else increment `sym_idx` and go to DAT_COL.
- FIN: `done` = 1 for one cycle, `busy` drops, go to IDLE.
- `start` while `busy` is ignored; latched `mod_sel` and `n_sym` do not change mid-frame.
- Upstream stalls (`enc_vld` low) only lengthen COL states. Emitted groups are never split.

## Timing
- Reset (`rst` low, asynchronous): state IDLE. All outputs 0: `enc_rdy`, `stmu_di`, `stmu_di_vld`, `dtmu_di`, `dtmu_di_vld`, `sym_first`, `tone_idx`, `sym_idx`, `busy`, `done`. Staging register cleared.
- Reset mid-frame: partial groups are discarded, no `done` is issued, and the next frame requires a new `start`.
- `busy` rises the cycle after the accepted `start`; `enc_rdy` rises in that same cycle.
- Latency: the k-th bit is accepted at edge t. The first emitted `*_di_vld` is registered high at edge t+1, and the last at edge t+k.
- `di_vld` gaps:
  - Between consecutive tone groups there is at least one cycle with `di_vld` = 0, since collection takes ≥ 1 cycle.
  - The downstream bit counter therefore always restarts aligned to a tone.
- Best case with continuous `enc_vld`: one tone per 2k cycles. The signal symbol takes 1920 cycles.
- `sym_first` coincides with the first `di_vld` cycle of tone 0, for both signal and data symbols.
- `tone_idx` and `sym_idx` are stable throughout each emit burst.
- `done`:
  - Registered high the cycle after the last emitted bit of the frame.
  - `busy` is low in the same cycle as `done`.
  - A `start` in the `done` cycle is ignored; IDLE is entered the following cycle.

## Test plan
- Bit order: after `start`, feed the signal bits 1,0 → `stmu_di` = 1 then 0 on two consecutive cycles with `stmu_di_vld` high; the downstream mapper output is 2'b01; `tone_idx` = 0 and `sym_first` = 1 on the first cycle.
- Signal-only frame: `n_sym` = 0, 960 bits with continuous `enc_vld` → 480 two-cycle `stmu_di_vld` bursts, `dtmu_di_vld` never high, `done` pulses once, `busy` low afterward, `sym_first` asserted once.
- 16QAM frame: `mod_sel` = 2, `n_sym` = 2, 960 + 3840 bits → 480 QPSK groups, then 960 four-cycle `dtmu` bursts; `sym_first` asserted 3 times, at `sym_idx` 0, 1, 2; `tone_idx` wraps 479 → 0 twice.
- BPSK with random `enc_vld` gaps: `mod_sel` = 0, `n_sym` = 1, random stalls → `dtmu` bits match input order exactly, every group has `dtmu_di_vld` high for 1 cycle followed by ≥ 1 low cycle, and 480 tones total.
- Start while busy: pulse `start` with `mod_sel` = 1 mid-signal-phase → ignored; the latched modulation stays as originally set; exactly one `done`.
- Reset mid-data: assert `rst` low during DAT_EMIT → all outputs 0 immediately and no `done`; a new `start` runs a full frame correctly.

Source files
------------

// File: rtl/sig_data_tmu_sched.sv
// Frame scheduler between the channel encoder and the signal/data tone mappers.
// Collects one tone's worth of bits, then replays them gap-free to the selected mapper.
module sig_data_tmu_sched #(
   parameter int N_TONE = 480,
   parameter int SYM_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mod_sel,
   input  logic [SYM_W-1:0] n_sym,
   input  logic             enc_di,
   input  logic             enc_vld,
   output logic             enc_rdy,
   output logic             stmu_di,
   output logic             stmu_di_vld,
   output logic             dtmu_di,
   output logic             dtmu_di_vld,
   output logic             sym_first,
   output logic [8:0]       tone_idx,
   output logic [SYM_W-1:0] sym_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      SIG_COL,
      SIG_EMIT,
      DAT_COL,
      DAT_EMIT,
      FIN
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       mod_q;
   logic [SYM_W-1:0] nsym_q;
   logic [SYM_W-1:0] sym_cnt;
   logic [8:0]       tone_cnt;
   logic [1:0]       bit_cnt;
   logic [1:0]       k_last;
   logic [3:0]       stage;
   logic             accept_start;
   logic             take_bit;
   logic             group_end;
   logic             tone_wrap;

   // Index of the last bit in a tone group: QPSK for the signal symbol, latched modulation for data
   always_comb begin
      k_last = 2'd1;
      if (state == DAT_COL || state == DAT_EMIT) begin
         case (mod_q)
            2'd0:    k_last = 2'd0;
            2'd2:    k_last = 2'd3;
            default: k_last = 2'd1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // The done cycle is already IDLE, so a start coinciding with done is masked here
   always_comb begin
      state_nxt    = state;
      enc_rdy      = 1'b0;
      accept_start = 1'b0;
      take_bit     = 1'b0;
      group_end    = 1'b0;
      tone_wrap    = (tone_cnt == 9'(N_TONE - 1));
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept_start = 1'b1;
               state_nxt    = SIG_COL;
            end
         end
         SIG_COL, DAT_COL: begin
            enc_rdy  = 1'b1;
            take_bit = enc_vld;
            if (enc_vld && bit_cnt == k_last) begin
               if (state == SIG_COL) state_nxt = SIG_EMIT;
               else                  state_nxt = DAT_EMIT;
            end
         end
         SIG_EMIT: begin
            if (bit_cnt == k_last) begin
               group_end = 1'b1;
               if (!tone_wrap)       state_nxt = SIG_COL;
               else if (nsym_q != 0) state_nxt = DAT_COL;
               else                  state_nxt = FIN;
            end
         end
         DAT_EMIT: begin
            if (bit_cnt == k_last) begin
               group_end = 1'b1;
               if (!tone_wrap)             state_nxt = DAT_COL;
               else if (sym_cnt == nsym_q) state_nxt = FIN;
               else                        state_nxt = DAT_COL;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Emit outputs lag the EMIT state by one edge; tone/sym indices are snapshotted per bit so they stay stable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mod_q       <= 2'd0;
         nsym_q      <= '0;
         sym_cnt     <= '0;
         tone_cnt    <= 9'd0;
         bit_cnt     <= 2'd0;
         stage       <= 4'd0;
         stmu_di     <= 1'b0;
         stmu_di_vld <= 1'b0;
         dtmu_di     <= 1'b0;
         dtmu_di_vld <= 1'b0;
         sym_first   <= 1'b0;
         tone_idx    <= 9'd0;
         sym_idx     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy        <= (state_nxt != IDLE);
         done        <= (state == FIN);
         stmu_di     <= 1'b0;
         stmu_di_vld <= 1'b0;
         dtmu_di     <= 1'b0;
         dtmu_di_vld <= 1'b0;
         sym_first   <= 1'b0;
         if (accept_start) begin
            mod_q    <= mod_sel;
            nsym_q   <= n_sym;
            sym_cnt  <= '0;
            tone_cnt <= 9'd0;
            bit_cnt  <= 2'd0;
            stage    <= 4'd0;
            tone_idx <= 9'd0;
            sym_idx  <= '0;
         end
         if (take_bit) begin
            stage[bit_cnt] <= enc_di;
            bit_cnt        <= (bit_cnt == k_last) ? 2'd0 : bit_cnt + 2'd1;
         end
         if (state == SIG_EMIT || state == DAT_EMIT) begin
            if (state == SIG_EMIT) begin
               stmu_di     <= stage[bit_cnt];
               stmu_di_vld <= 1'b1;
            end else begin
               dtmu_di     <= stage[bit_cnt];
               dtmu_di_vld <= 1'b1;
            end
            sym_first <= (bit_cnt == 2'd0) && (tone_cnt == 9'd0);
            tone_idx  <= tone_cnt;
            sym_idx   <= sym_cnt;
            bit_cnt   <= group_end ? 2'd0 : bit_cnt + 2'd1;
            if (group_end) begin
               if (tone_wrap) begin
                  tone_cnt <= 9'd0;
                  if (state == SIG_EMIT)      sym_cnt <= SYM_W'(1);
                  else if (sym_cnt != nsym_q) sym_cnt <= sym_cnt + SYM_W'(1);
               end else begin
                  tone_cnt <= tone_cnt + 9'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sig_data_tmu_sched.sv
// Directed frames with a bit-order scoreboard: every accepted encoder bit is queued with its
// expected port, tone, symbol and first-flag, and popped when a mapper strobe appears.
module tb_sig_data_tmu_sched;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mod_sel;
   logic [7:0] n_sym;
   logic       enc_di;
   logic       enc_vld;
   logic       enc_rdy;
   logic       stmu_di;
   logic       stmu_di_vld;
   logic       dtmu_di;
   logic       dtmu_di_vld;
   logic       sym_first;
   logic [8:0] tone_idx;
   logic [7:0] sym_idx;
   logic       busy;
   logic       done;

   typedef struct {
      int port;
      int b;
      int tone;
      int sym;
      int first;
      int k;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   done_cnt   = 0;
   int   first_cnt  = 0;
   int   vld_run    = 0;
   int   run_k      = 0;

   sig_data_tmu_sched #(.N_TONE(480), .SYM_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mod_sel     (mod_sel),
      .n_sym       (n_sym),
      .enc_di      (enc_di),
      .enc_vld     (enc_vld),
      .enc_rdy     (enc_rdy),
      .stmu_di     (stmu_di),
      .stmu_di_vld (stmu_di_vld),
      .dtmu_di     (dtmu_di),
      .dtmu_di_vld (dtmu_di_vld),
      .sym_first   (sym_first),
      .tone_idx    (tone_idx),
      .sym_idx     (sym_idx),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({enc_rdy, stmu_di, stmu_di_vld, dtmu_di, dtmu_di_vld,
                  sym_first, busy, done, tone_idx, sym_idx});
   endfunction

   // Monitor: pop one expected bit per strobe cycle, check burst lengths when a strobe run ends
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         vld_run = 0;
      end else begin
         if (stmu_di_vld || dtmu_di_vld) begin
            check_output("dual_vld", 32'(stmu_di_vld & dtmu_di_vld), 32'd0);
            vld_run++;
            if (sym_first) first_cnt++;
            if (sb.size() == 0) begin
               check_output("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               run_k = e.k;
               check_output("port", 32'(dtmu_di_vld), 32'(e.port));
               check_output("di", dtmu_di_vld ? 32'(dtmu_di) : 32'(stmu_di), 32'(e.b));
               check_output("other_di", dtmu_di_vld ? 32'(stmu_di) : 32'(dtmu_di), 32'd0);
               check_output("tone_idx", 32'(tone_idx), 32'(e.tone));
               check_output("sym_idx", 32'(sym_idx), 32'(e.sym));
               check_output("sym_first", 32'(sym_first), 32'(e.first));
            end
         end else if (vld_run != 0) begin
            check_output("burst_len", 32'(vld_run), 32'(run_k));
            vld_run = 0;
         end
         if (done) begin
            done_cnt++;
            check_output("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // One frame: start, feed every bit (optional stalls / mid-frame start / reset abort), wait for done
   task automatic apply_stimulus(input logic [1:0] mod, input int nsym, input int stall_pct,
                                 input int busy_start_at, input int abort_at);
      int   k;
      int   total;
      int   d0;
      int   f0;
      int   tries;
      int   j;
      logic acc;
      logic got;
      logic b;
      exp_t e;
      k     = (mod == 2'd0) ? 1 : (mod == 2'd2) ? 4 : 2;
      total = 960 + nsym * 480 * k;
      d0    = done_cnt;
      f0    = first_cnt;
      check_output("idle_busy", 32'(busy), 32'd0);
      mod_sel = mod;
      n_sym   = 8'(nsym);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_output("busy_rise", 32'(busy), 32'd1);
      check_output("rdy_rise", 32'(enc_rdy), 32'd1);
      for (int i = 0; i < total; i++) begin
         b = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(1));
         e.b = int'(b);
         if (i < 960) begin
            e.port = 0; e.tone = i / 2; e.sym = 0; e.first = (i == 0) ? 1 : 0; e.k = 2;
         end else begin
            j = i - 960;
            e.port  = 1;
            e.tone  = (j / k) % 480;
            e.sym   = j / (480 * k) + 1;
            e.first = (j % (480 * k) == 0) ? 1 : 0;
            e.k     = k;
         end
         if (stall_pct > 0) begin
            while (int'($urandom_range(99)) < stall_pct) begin
               enc_vld = 1'b0;
               @(posedge clk); #1;
            end
         end
         enc_vld = 1'b1;
         enc_di  = b;
         acc     = 1'b0;
         tries   = 0;
         while (!acc && tries < 50) begin
            @(negedge clk);
            if (enc_rdy) begin
               acc = 1'b1;
               sb.push_back(e);
            end
            @(posedge clk); #1;
            tries++;
         end
         enc_vld = 1'b0;
         if (!acc) begin
            check_output("rdy_timeout", 32'(acc), 32'd1);
            return;
         end
         if (i == abort_at) begin
            check_output("abort_in_emit", 32'(enc_rdy), 32'd0);
            rst = 1'b0;
            #1;
            check_output("rst_outputs", out_vec(), 32'd0);
            sb.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check_output("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
            check_output("idle_after_rst", 32'({busy, enc_rdy}), 32'd0);
            return;
         end
         if (i == busy_start_at) begin
            start   = 1'b1;
            mod_sel = 2'd1;
            n_sym   = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
            check_output("busy_hold", 32'(busy), 32'd1);
         end
      end
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (done) begin
            got   = 1'b1;
            start = 1'b1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check_output("done_seen", 32'(got), 32'd1);
      check_output("start_in_done_ignored", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_output("done_once", 32'(done_cnt - d0), 32'd1);
      check_output("first_count", 32'(first_cnt - f0), 32'(nsym + 1));
      check_output("sb_drained", 32'(sb.size()), 32'd0);
      check_output("idle_after", 32'({busy, enc_rdy, done}), 32'd0);
   endtask

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      mod_sel = 2'd0;
      n_sym   = 8'd0;
      enc_di  = 1'b0;
      enc_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_outputs", out_vec(), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      $display("[TB] signal-only frame");
      apply_stimulus(2'd1, 0, 0, -1, -1);
      $display("[TB] 16QAM frame, two data symbols");
      apply_stimulus(2'd2, 2, 0, -1, -1);
      $display("[TB] BPSK frame with random stalls");
      apply_stimulus(2'd0, 1, 30, -1, -1);
      $display("[TB] start pulse while busy");
      apply_stimulus(2'd0, 1, 0, 100, -1);
      $display("[TB] reset during data emit");
      apply_stimulus(2'd1, 2, 0, -1, 960 + 21);
      $display("[TB] reserved modulation frame after reset");
      apply_stimulus(2'd3, 1, 10, -1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
